aer_evt_decoder: RTL

Event decode/timestamp stage between the AER receiver handshake FSM and the decoded-data RX FIFO. Accepts the receiver's raw AER word stream (row address, one or more column addresses, tailword), forms one decoded event per column, applies the ROI filter and stamps each event with the time at which its row arrived. It emits 32-bit words {timestamp[15:0], y[7:0], x[7:0]} on a valid/ready interface to the FIFO, and keeps event, drop and error counters for the register file.

---
 rtl/aer_evt_decoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/aer_evt_decoder.sv
// AER event decoder: turns row/column/tailword streams into timestamped {ts, y, x}
// words, with an optional ROI filter and saturating event/drop/error counters.
module aer_evt_decoder #(
    parameter int IMG_SIZE        = 32,
    parameter int AER_DWIDTH      = $clog2(IMG_SIZE) + 1,
    parameter int OH_DEC_WIDTH    = 8,
    parameter int TIMESTAMP_WIDTH = 16,
    parameter int TIME_RES_WIDTH  = 16,
    parameter int EVT_CTR_WIDTH   = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      en,
    input  logic [TIME_RES_WIDTH-1:0]                 time_res,
    input  logic [31:0]                               roi,
    input  logic                                      roi_en,
    input  logic                                      cnt_clr,
    input  logic                                      in_valid,
    input  logic [AER_DWIDTH-1:0]                     in_data,
    output logic                                      in_ready,
    output logic                                      out_valid,
    output logic [TIMESTAMP_WIDTH+2*OH_DEC_WIDTH-1:0] out_data,
    input  logic                                      out_ready,
    output logic                                      ts_wrap,
    output logic [EVT_CTR_WIDTH-1:0]                  evt_cnt,
    output logic [EVT_CTR_WIDTH-1:0]                  drop_cnt,
    output logic [EVT_CTR_WIDTH-1:0]                  err_cnt
);
    // state    | meaning
    // WAIT_ROW | expecting a row address word
    // WAIT_COL | row latched; column words emit events until a tailword
    localparam int AW = $clog2(IMG_SIZE);
    localparam logic [AER_DWIDTH-1:0] AER_TAILWORD = '1;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] w;
        logic [7:0] y;
        logic [7:0] x;
    } roi_t;

    typedef enum logic {WAIT_ROW = 1'b0, WAIT_COL = 1'b1} state_t;

    state_t                     state;
    logic [AW-1:0]              y_reg;
    logic [AW-1:0]              addr;
    logic [TIMESTAMP_WIDTH-1:0] ts;
    logic [TIMESTAMP_WIDTH-1:0] ts_row;
    logic [TIME_RES_WIDTH-1:0]  prescaler;
    roi_t                       roi_r;
    logic                       accept, is_addr, is_tail, is_err;
    logic                       roi_pass, evt, load, drop, err;
    logic [8:0]                 x9, y9, x_lo, x_hi, y_lo, y_hi;

    function automatic logic [EVT_CTR_WIDTH-1:0] sat_inc(
        input logic [EVT_CTR_WIDTH-1:0] c,
        input logic                     inc
    );
        return (inc && !(&c)) ? c + EVT_CTR_WIDTH'(1) : c;
    endfunction

    assign roi_r    = roi_t'(roi);
    assign addr     = in_data[AW-1:0];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_addr  = !in_data[AER_DWIDTH-1];
    assign is_tail  = (in_data == AER_TAILWORD);
    assign is_err   = !is_addr && !is_tail;

    // 9-bit bounds so x+w / y+h cannot overflow back into range
    always_comb begin
        x9       = 9'(addr);
        y9       = 9'(y_reg);
        x_lo     = {1'b0, roi_r.x};
        x_hi     = {1'b0, roi_r.x} + {1'b0, roi_r.w};
        y_lo     = {1'b0, roi_r.y};
        y_hi     = {1'b0, roi_r.y} + {1'b0, roi_r.h};
        roi_pass = !roi_en || ((x9 >= x_lo) && (x9 < x_hi) && (y9 >= y_lo) && (y9 < y_hi));
    end

    assign evt  = accept && en && (state == WAIT_COL) && is_addr;
    assign load = evt && roi_pass;
    assign drop = evt && !roi_pass;
    assign err  = accept && en && is_err;

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            prescaler <= '0;
            ts        <= '0;
            ts_wrap   <= 1'b0;
        end else if (prescaler >= time_res) begin
            prescaler <= '0;
            ts        <= ts + TIMESTAMP_WIDTH'(1);
            ts_wrap   <= &ts;
        end else begin
            prescaler <= prescaler + TIME_RES_WIDTH'(1);
            ts_wrap   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            evt_cnt  <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            evt_cnt  <= sat_inc(evt_cnt, load);
            drop_cnt <= sat_inc(drop_cnt, drop);
            err_cnt  <= sat_inc(err_cnt, err);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_ROW;
            y_reg     <= '0;
            ts_row    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= {ts_row, OH_DEC_WIDTH'(y_reg), OH_DEC_WIDTH'(addr)};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (!en) begin
                state <= WAIT_ROW;
            end else if (accept) begin
                case (state)
                    WAIT_ROW: begin
                        if (is_addr) begin
                            y_reg  <= addr;
                            ts_row <= ts;
                            state  <= WAIT_COL;
                        end
                    end
                    WAIT_COL: begin
                        if (is_tail || is_err) state <= WAIT_ROW;
                    end
                endcase
            end
        end
    end
endmodule
